// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared UC opcodes, register/ULA controls and sequencer states
package uc_pkg;

   localparam int UC_FUNC_W = 4;

   localparam logic [UC_FUNC_W-1:0] F_CLR = 4'd0;
   localparam logic [UC_FUNC_W-1:0] F_LD1 = 4'd1;
   localparam logic [UC_FUNC_W-1:0] F_LD2 = 4'd2;
   localparam logic [UC_FUNC_W-1:0] F_LD3 = 4'd3;
   localparam logic [UC_FUNC_W-1:0] F_DIV = 4'd4;
   localparam logic [UC_FUNC_W-1:0] F_DIS = 4'd5;
   localparam logic [UC_FUNC_W-1:0] F_RES = 4'd6;

   // Register controls and ULA controls that UC derives from func
   localparam logic [1:0] REG_HOLD   = 2'd0;
   localparam logic [1:0] REG_LOAD   = 2'd1;
   localparam logic [1:0] REG_SHIFTR = 2'd2;
   localparam logic [1:0] REG_RESET  = 2'd3;
   localparam logic       ULA_DC     = 1'b0;
   localparam logic       ULA_ADD    = 1'b1;

   typedef enum logic [3:0] {
      S_INIT  = 4'd0,
      S_IDLE  = 4'd1,
      S_CLR   = 4'd2,
      S_WAIT1 = 4'd3,
      S_LD1   = 4'd4,
      S_WAIT2 = 4'd5,
      S_LD2   = 4'd6,
      S_WAIT3 = 4'd7,
      S_LD3   = 4'd8,
      S_DIV   = 4'd9,
      S_DIS   = 4'd10,
      S_DONE  = 4'd11,
      S_ABORT = 4'd12
   } seq_state_t;

endpackage

// File: rtl/uc_sequencer.sv
// rtl/uc_sequencer.sv - Moore FSM sequencing one averaging job onto the UC func opcode
module uc_sequencer
   import uc_pkg::*;
#(
   parameter int N_SHIFT = 1,
   parameter int FUNC_W  = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [FUNC_W-1:0] func,
   output logic              busy,
   output logic              done
);

   seq_state_t state;
   seq_state_t state_next;
   logic [2:0] div_cnt;
   logic       abortable;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_INIT;
      end else begin
         state <= state_next;
      end
   end

   // DIV length counter: loaded while leaving LD3, counts down inside DIV
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= 3'd0;
      end else if (state == S_LD3) begin
         div_cnt <= 3'(N_SHIFT - 1);
      end else if (state == S_DIV && div_cnt != 3'd0) begin
         div_cnt <= div_cnt - 3'd1;
      end
   end

   always_comb begin
      abortable  = !(state == S_INIT || state == S_IDLE || state == S_ABORT);
      state_next = state;
      case (state)
         S_INIT:  state_next = S_IDLE;
         S_IDLE:  if (start) state_next = S_CLR;
         S_CLR:   state_next = S_WAIT1;
         S_WAIT1: if (in_valid) state_next = S_LD1;
         S_LD1:   state_next = S_WAIT2;
         S_WAIT2: if (in_valid) state_next = S_LD2;
         S_LD2:   state_next = S_WAIT3;
         S_WAIT3: if (in_valid) state_next = S_LD3;
         S_LD3:   state_next = S_DIV;
         S_DIV:   if (div_cnt == 3'd0) state_next = S_DIS;
         S_DIS:   state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         S_ABORT: state_next = S_IDLE;
         default: state_next = S_INIT;
      endcase
      // abort overrides every busy-state transition, including operand and DIV exits
      if (abort && abortable) begin
         state_next = S_ABORT;
      end
   end

   always_comb begin
      func     = FUNC_W'(F_CLR);
      in_ready = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      case (state)
         S_INIT:  busy = 1'b0;
         S_IDLE:  begin func = FUNC_W'(F_RES); busy = 1'b0; end
         S_CLR:   func = FUNC_W'(F_CLR);
         S_WAIT1,
         S_WAIT2,
         S_WAIT3: begin func = FUNC_W'(F_RES); in_ready = 1'b1; end
         S_LD1:   func = FUNC_W'(F_LD1);
         S_LD2:   func = FUNC_W'(F_LD2);
         S_LD3:   func = FUNC_W'(F_LD3);
         S_DIV:   func = FUNC_W'(F_DIV);
         S_DIS:   func = FUNC_W'(F_DIS);
         S_DONE:  begin func = FUNC_W'(F_RES); done = 1'b1; end
         S_ABORT: func = FUNC_W'(F_CLR);
         default: begin func = FUNC_W'(F_CLR); busy = 1'b0; end
      endcase
   end

endmodule

// File: tb/tb_uc_sequencer.sv
// tb/tb_uc_sequencer.sv - self-checking bench for uc_sequencer with N_SHIFT=1 and N_SHIFT=3
module tb_uc_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready1, busy1, done1;
   logic       in_ready3, busy3, done3;
   logic [3:0] func1, func3;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uc_sequencer #(.N_SHIFT(1), .FUNC_W(4)) dut1 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
      .in_ready(in_ready1), .func(func1), .busy(busy1), .done(done1)
   );

   uc_sequencer #(.N_SHIFT(3), .FUNC_W(4)) dut3 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
      .in_ready(in_ready3), .func(func3), .busy(busy3), .done(done3)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Job model: a flat program of steps
   //   0 CLR, 1 wait, 2 LD1, 3 wait, 4 LD2, 5 wait, 6 LD3, 7..6+n DIV, 7+n DIS, 8+n DONE
   // plus -2 = INIT, -1 = IDLE, -3 = abort clear.
   function automatic bit is_wait(input int p);
      return (p == 1 || p == 3 || p == 5);
   endfunction

   function automatic logic [7:0] exp_func(input int n, input int p);
      if (p == -2 || p == -3 || p == 0) return 8'd0;
      if (p == -1 || is_wait(p))        return 8'd6;
      if (p == 2)                       return 8'd1;
      if (p == 4)                       return 8'd2;
      if (p == 6)                       return 8'd3;
      if (p < 7 + n)                    return 8'd4;
      if (p == 7 + n)                   return 8'd5;
      return 8'd6;
   endfunction

   function automatic int next_pos(input int n, input int p, input bit st, input bit ab, input bit iv);
      if (p == -2 || p == -3) return -1;
      if (p == -1)            return st ? 0 : -1;
      if (ab)                 return -3;
      if (is_wait(p) && !iv)  return p;
      if (p == 8 + n)         return -1;
      return p + 1;
   endfunction

   int m_pos1 = -2;
   int m_pos3 = -2;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pos1 <= -2;
         m_pos3 <= -2;
      end else begin
         m_pos1 <= next_pos(1, m_pos1, start, abort, in_valid);
         m_pos3 <= next_pos(3, m_pos3, start, abort, in_valid);
      end
   end

   always @(negedge clk) begin
      chk("model1_func",  8'(func1),     exp_func(1, m_pos1));
      chk("model1_ready", 8'(in_ready1), 8'(is_wait(m_pos1)));
      chk("model1_busy",  8'(busy1),     8'(m_pos1 >= 0 || m_pos1 == -3));
      chk("model1_done",  8'(done1),     8'(m_pos1 == 9));
      chk("model3_func",  8'(func3),     exp_func(3, m_pos3));
      chk("model3_ready", 8'(in_ready3), 8'(is_wait(m_pos3)));
      chk("model3_busy",  8'(busy3),     8'(m_pos3 >= 0 || m_pos3 == -3));
      chk("model3_done",  8'(done3),     8'(m_pos3 == 11));
   end

   logic [3:0] t1 [10] = '{4'd0, 4'd6, 4'd1, 4'd6, 4'd2, 4'd6, 4'd3, 4'd4, 4'd5, 4'd6};
   logic [3:0] t3 [12] = '{4'd0, 4'd6, 4'd1, 4'd6, 4'd2, 4'd6, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5, 4'd6};

   initial begin
      // reset and release
      repeat (2) @(negedge clk);
      chk("rst_func",  8'(func1), 8'd0);
      chk("rst_busy",  8'(busy1), 8'd0);
      chk("rst_done",  8'(done1), 8'd0);
      chk("rst_ready", 8'(in_ready1), 8'd0);
      rst = 1'b0;
      #1 chk("release_func", 8'(func1), 8'd0);
      @(negedge clk);
      chk("idle_func", 8'(func1), 8'd6);
      chk("idle_busy", 8'(busy1), 8'd0);
      chk("idle_done", 8'(done1), 8'd0);

      // full job, operands always ready
      in_valid = 1'b1;
      start = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (i < 10) begin
            chk("job1_func", 8'(func1), 8'(t1[i]));
            chk("job1_done", 8'(done1), 8'(i == 9));
         end
         chk("job3_func", 8'(func3), 8'(t3[i]));
         chk("job3_done", 8'(done3), 8'(i == 11));
      end
      @(negedge clk);
      chk("job_after_func1", 8'(func1), 8'd6);
      chk("job_after_func3", 8'(func3), 8'd6);
      chk("job_after_busy3", 8'(busy3), 8'd0);

      // slow operand in WAIT2, then the N_SHIFT=3 DIV run
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("slow_clr", 8'(func1), 8'd0);
      @(negedge clk);
      chk("slow_wait1", 8'(func1), 8'd6);
      @(negedge clk);
      chk("slow_ld1", 8'(func1), 8'd1);
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("slow_wait2_func",  8'(func1), 8'd6);
         chk("slow_wait2_ready", 8'(in_ready1), 8'd1);
         chk("slow_wait2_func3", 8'(func3), 8'd6);
      end
      in_valid = 1'b1;
      @(negedge clk);
      chk("slow_ld2", 8'(func1), 8'd2);
      @(negedge clk);
      chk("slow_no_repeat_ld2", 8'(func1), 8'd6);
      @(negedge clk);
      chk("slow_ld3", 8'(func3), 8'd3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("div3_func", 8'(func3), 8'd4);
      end
      @(negedge clk);
      chk("div3_dis", 8'(func3), 8'd5);
      @(negedge clk);
      chk("div3_done", 8'(done3), 8'd1);
      @(negedge clk);
      chk("div3_idle", 8'(func3), 8'd6);
      chk("div3_done_clear", 8'(done3), 8'd0);

      // abort during the second DIV cycle of the N_SHIFT=3 job
      start = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         start = 1'b0;
         chk("abort_pre_done", 8'(done3), 8'd0);
      end
      chk("abort_at_div2", 8'(func3), 8'd4);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_clr", 8'(func3), 8'd0);
      chk("abort_clr_done", 8'(done3), 8'd0);
      @(negedge clk);
      chk("abort_idle", 8'(func3), 8'd6);
      chk("abort_idle_busy", 8'(busy3), 8'd0);
      chk("abort_idle_done", 8'(done3), 8'd0);

      // start while busy is ignored; restart from the IDLE after DONE
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_start_clr", 8'(func1), 8'd0);
      @(negedge clk);
      chk("busy_start_wait1", 8'(func1), 8'd6);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_start_ignored", 8'(func1), 8'd1);
      repeat (7) @(negedge clk);
      chk("restart_done", 8'(done1), 8'd1);
      start = 1'b1;
      @(negedge clk);
      chk("restart_not_from_done", 8'(func1), 8'd6);
      @(negedge clk);
      start = 1'b0;
      chk("restart_from_idle", 8'(func1), 8'd0);

      // asynchronous reset mid-job
      repeat (3) @(negedge clk);
      chk("midjob_busy", 8'(busy1), 8'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_func1", 8'(func1), 8'd0);
      chk("async_rst_busy1", 8'(busy1), 8'd0);
      chk("async_rst_func3", 8'(func3), 8'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", 8'(func1), 8'd6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
